// File: rtl/cpu_pkg.sv
// Shared CPU encodings: fetch FSM states and register-file codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_FETCH_LO = 2'b01,
    S_FETCH_HI = 2'b10,
    S_HOLD     = 2'b11
  } fetch_state_t;

  localparam logic [1:0] FUNSEL_DEC   = 2'b00;
  localparam logic [1:0] FUNSEL_INC   = 2'b01;
  localparam logic [1:0] FUNSEL_LOAD  = 2'b10;
  localparam logic [1:0] FUNSEL_CLEAR = 2'b11;

  localparam logic [1:0] OUTDSEL_PC = 2'b00;
  localparam logic [1:0] OUTDSEL_AR = 2'b01;
  localparam logic [1:0] OUTDSEL_SP = 2'b10;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter that sticks at 16'hFFFF.
module sat_counter16 (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        i_inc,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count <= 16'h0000;
    end else if (i_inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch sequencer with IR handshake.
// Optional instruction counter enabled by FETCH_PERF_CNT_EN.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [1:0] INC_FUNSEL   = FUNSEL_INC,
  parameter logic       AUTO_RESTART = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Flush,
  input  logic [7:0]  MemData,
  input  logic        IR_Ready,
  output logic [2:0]  ARF_RegSel,
  output logic [1:0]  ARF_FunSel,
  output logic [1:0]  ARF_OutDSel,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic [15:0] IR_Out,
  output logic        IR_Valid,
  output logic [15:0] InstrCount
);

  fetch_state_t r_state;
  logic [15:0]  r_ir;
  logic         r_valid;
  logic         w_fetch;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_ir    <= 16'h0000;
      r_valid <= 1'b0;
    end else if (Flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Start) r_state <= S_FETCH_LO;
        end
        S_FETCH_LO: begin
          r_ir[7:0] <= MemData;
          r_state   <= S_FETCH_HI;
        end
        S_FETCH_HI: begin
          r_ir[15:8] <= MemData;
          r_valid    <= 1'b1;
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          if (IR_Ready) begin
            r_valid <= 1'b0;
            if (Start && AUTO_RESTART)
              r_state <= S_FETCH_LO;
            else
              r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_fetch = (r_state == S_FETCH_LO) ||
                   (r_state == S_FETCH_HI);

  // Flush kills the PC increment of the cycle it arrives in
  assign ARF_RegSel  = {2'b00, w_fetch & ~Flush};
  assign ARF_FunSel  = w_fetch ? INC_FUNSEL : FUNSEL_DEC;
  assign ARF_OutDSel = OUTDSEL_PC;
  assign Mem_CS      = ~w_fetch;
  assign Mem_WR      = 1'b0;
  assign IR_Out      = r_ir;
  assign IR_Valid    = r_valid;

`ifdef FETCH_PERF_CNT_EN
  logic w_hs;

  assign w_hs = (r_state == S_HOLD) & IR_Ready & ~Flush;

  sat_counter16 u_cnt (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_inc   (w_hs),
    .o_count (InstrCount)
  );
`else
  assign InstrCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + random bench for fetch_sequencer with a memory/PC model.
module tb_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Flush;
  logic [7:0]  MemData;
  logic        IR_Ready;
  logic [2:0]  ARF_RegSel;
  logic [1:0]  ARF_FunSel;
  logic [1:0]  ARF_OutDSel;
  logic        Mem_CS;
  logic        Mem_WR;
  logic [15:0] IR_Out;
  logic        IR_Valid;
  logic [15:0] InstrCount;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [7:0]  mem [256];
  logic [15:0] pc = 16'h0000;
  logic [15:0] exp_pc = 16'h0000;
  int          exp_cnt = 0;

  always #5 Clock = ~Clock;

  fetch_sequencer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Flush       (Flush),
    .MemData     (MemData),
    .IR_Ready    (IR_Ready),
    .ARF_RegSel  (ARF_RegSel),
    .ARF_FunSel  (ARF_FunSel),
    .ARF_OutDSel (ARF_OutDSel),
    .Mem_CS      (Mem_CS),
    .Mem_WR      (Mem_WR),
    .IR_Out      (IR_Out),
    .IR_Valid    (IR_Valid),
    .InstrCount  (InstrCount)
  );

  // External PC register driven by the DUT's enables
  always @(posedge Clock)
    if (ARF_RegSel[0] && ARF_FunSel == 2'b01)
      pc <= pc + 16'd1;

  assign MemData = mem[pc[7:0]];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp();
`ifdef FETCH_PERF_CNT_EN
    return (exp_cnt > 65535) ? 32'hFFFF : 32'(exp_cnt);
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [15:0] instr_at(input logic [15:0] a);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = a[7:0];
    hi = lo + 8'd1;
    return {mem[hi], mem[lo]};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_regsel"}, 32'(ARF_RegSel), 0);
    chk({tag, "_funsel"}, 32'(ARF_FunSel), 0);
    chk({tag, "_outdsel"}, 32'(ARF_OutDSel), 0);
    chk({tag, "_cs"}, 32'(Mem_CS), 1);
    chk({tag, "_wr"}, 32'(Mem_WR), 0);
    chk({tag, "_ir"}, 32'(IR_Out), 0);
    chk({tag, "_valid"}, 32'(IR_Valid), 0);
    chk({tag, "_cnt"}, 32'(InstrCount), 0);
  endtask

  initial begin
    logic [15:0] base;
    int          mode;
    int          wt;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h34;
    mem[1] = 8'h12;
    Reset = 1'b0; Start = 1'b0; Flush = 1'b0; IR_Ready = 1'b0;
    #12;
    chk_reset_vals("rst");
    Reset = 1'b1;
    step();

    // Basic fetch with latency check
    Start = 1'b1;
    step();
    chk("lo_valid", 32'(IR_Valid), 0);
    chk("lo_regsel", 32'(ARF_RegSel), 1);
    chk("lo_cs", 32'(Mem_CS), 0);
    chk("lo_funsel", 32'(ARF_FunSel), 1);
    step();
    chk("hi_valid", 32'(IR_Valid), 0);
    chk("hi_regsel", 32'(ARF_RegSel), 1);
    step();
    chk("hold_valid", 32'(IR_Valid), 1);
    chk("hold_ir", 32'(IR_Out), 32'h1234);
    chk("hold_cs", 32'(Mem_CS), 1);
    chk("hold_regsel", 32'(ARF_RegSel), 0);
    exp_pc = 16'd2;
    chk("hold_pc", 32'(pc), 32'(exp_pc));
    Start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("wait_valid", 32'(IR_Valid), 1);
      chk("wait_ir", 32'(IR_Out), 32'h1234);
      chk("wait_cs", 32'(Mem_CS), 1);
      chk("wait_pc", 32'(pc), 32'(exp_pc));
    end
    IR_Ready = 1'b1;
    step();
    IR_Ready = 1'b0;
    exp_cnt++;
    chk("hs_valid", 32'(IR_Valid), 0);
    chk("hs_cnt", 32'(InstrCount), cnt_exp());
    step();
    chk("idle_cs", 32'(Mem_CS), 1);

    // Flush during FETCH_HI
    Start = 1'b1;
    step();
    step();
    Flush = 1'b1;
    Start = 1'b0;
    #1;
    chk("flhi_regsel", 32'(ARF_RegSel), 0);
    step();
    Flush = 1'b0;
    exp_pc = exp_pc + 16'd1;
    chk("flhi_valid", 32'(IR_Valid), 0);
    chk("flhi_cs", 32'(Mem_CS), 1);
    chk("flhi_pc", 32'(pc), 32'(exp_pc));
    step();
    chk("flhi_pc2", 32'(pc), 32'(exp_pc));

    // Flush and handshake together in HOLD
    base = exp_pc;
    Start = 1'b1;
    step(); step(); step();
    chk("flh_valid1", 32'(IR_Valid), 1);
    chk("flh_ir", 32'(IR_Out), 32'(instr_at(base)));
    Flush = 1'b1; IR_Ready = 1'b1; Start = 1'b0;
    step();
    Flush = 1'b0; IR_Ready = 1'b0;
    exp_pc = exp_pc + 16'd2;
    chk("flh_valid0", 32'(IR_Valid), 0);
    chk("flh_cnt", 32'(InstrCount), cnt_exp());
    chk("flh_pc", 32'(pc), 32'(exp_pc));
    step();
    chk("flh_idle", 32'(Mem_CS), 1);

    // Three back-to-back instructions
    Start = 1'b1; IR_Ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      base = exp_pc;
      step();
      chk("b2b_lo", 32'(Mem_CS), 0);
      step();
      chk("b2b_hi", 32'(Mem_CS), 0);
      step();
      chk("b2b_valid", 32'(IR_Valid), 1);
      chk("b2b_ir", 32'(IR_Out), 32'(instr_at(base)));
      exp_pc = exp_pc + 16'd2;
      exp_cnt++;
      if (n == 2) Start = 1'b0;
    end
    step();
    IR_Ready = 1'b0;
    chk("b2b_end_valid", 32'(IR_Valid), 0);
    chk("b2b_cnt", 32'(InstrCount), cnt_exp());
    chk("b2b_pc", 32'(pc), 32'(exp_pc));

    // Reset in the middle of FETCH_HI
    Start = 1'b1;
    step();
    step();
    Start = 1'b0;
    Reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    exp_pc = exp_pc + 16'd1;
    exp_cnt = 0;
    step(); step();
    chk("midrst_pc", 32'(pc), 32'(exp_pc));
    Reset = 1'b1;
    step();

    // Random transactions against the model
    for (int t = 0; t < 24; t++) begin
      base = exp_pc;
      mode = $urandom_range(0, 4);
      wt   = $urandom_range(0, 3);
      Start = 1'b1;
      step(); step();
      if (mode == 0) begin
        Flush = 1'b1; Start = 1'b0;
        step();
        Flush = 1'b0;
        exp_pc = exp_pc + 16'd1;
        chk("rnd_flhi_valid", 32'(IR_Valid), 0);
      end else begin
        step();
        chk("rnd_valid", 32'(IR_Valid), 1);
        chk("rnd_ir", 32'(IR_Out), 32'(instr_at(base)));
        Start = 1'b0;
        for (int w = 0; w < wt; w++) begin
          step();
          chk("rnd_wait_ir", 32'(IR_Out), 32'(instr_at(base)));
        end
        IR_Ready = 1'b1;
        if (mode == 1) Flush = 1'b1;
        else exp_cnt++;
        step();
        IR_Ready = 1'b0; Flush = 1'b0;
        exp_pc = exp_pc + 16'd2;
        chk("rnd_hs_valid", 32'(IR_Valid), 0);
      end
      chk("rnd_pc", 32'(pc), 32'(exp_pc));
      chk("rnd_cnt", 32'(InstrCount), cnt_exp());
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
